// File: rtl/nibble_serial_alu_seq.sv
// nibble_serial_alu_seq: shared add/sub sequencer, one 4-bit lookahead group per clock
module nibble_serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N = WIDTH / 4;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic carry_q, carry_d, cmsb_q, cmsb_d, vld_q, vld_d, last;
  logic [3:0] an, bn, g, p, s;
  logic [4:0] c;
  always_comb begin
    an = opa_q[4*cnt_q +: 4];
    bn = opb_q[4*cnt_q +: 4];
    g = an & bn;
    p = an | bn;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s = an ^ bn ^ c[3:0];
    last = cnt_q == CW'(N - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    opa_d = opa_q;
    opb_d = opb_q;
    result_d = result_q;
    carry_d = carry_q;
    cmsb_d = cmsb_q;
    vld_d = vld_q;
    if (state_q == IDLE && req) begin
      opa_d = a;
      opb_d = op[0] ? ~b : b;
      carry_d = op[1] ? cin : op[0];
      cnt_d = '0;
      result_d = '0;
      vld_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      result_d[4*cnt_q +: 4] = s;
      carry_d = c[4];
      cnt_d = last ? cnt_q : cnt_q + 1'b1;
      cmsb_d = last ? c[3] : cmsb_q;
      vld_d = last;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      result_q <= '0;
      carry_q <= 1'b0;
      cmsb_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      result_q <= result_d;
      carry_q <= carry_d;
      cmsb_q <= cmsb_d;
      vld_q <= vld_d;
    end
  end
  // flags are gated by vld_q so they read 0 from accept until the op completes
  assign ready = state_q == IDLE;
  assign done = state_q == DONE;
  assign result = result_q;
  assign cout = vld_q & carry_q;
  assign ovf = vld_q & (cmsb_q ^ carry_q);
  assign zero = vld_q & ~|result_q;
endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// tb_nibble_serial_alu_seq: directed vectors with a queued scoreboard checked on done
module tb_nibble_serial_alu_seq;
  localparam int N = 8;
  logic clk = 1'b0, reset, req, cin;
  logic [1:0] op;
  logic [31:0] a, b, result;
  logic ready, done, cout, ovf, zero;
  int cyc = 0, passed = 0, total = 0;
  typedef struct {logic [31:0] r; logic c, o, z; int acc;} exp_t;
  exp_t q[$];

  nibble_serial_alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("stray_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.r);
        chk("cout", {31'd0, cout}, {31'd0, e.c});
        chk("ovf", {31'd0, ovf}, {31'd0, e.o});
        chk("zero", {31'd0, zero}, {31'd0, e.z});
        chk("latency", cyc - e.acc, N + 1);
        chk("ready_in_done", {31'd0, ready}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic hold, input logic [31:0] er,
                       input logic ec, input logic eo, input logic ez);
    int n;
    exp_t e;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    req = 1'b1; op = o; a = x; b = y; cin = ci;
    e.r = er; e.c = ec; e.o = eo; e.z = ez; e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    n = 1;
    req = hold;
    op = 2'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
    while (!ready && n < 40) begin
      @(negedge clk);
      op = 2'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
      n++;
    end
    chk("ready_gap", n, N + 2);
  endtask

  initial begin
    int n;
    reset = 1'b1; req = 1'b0; op = 2'd0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(2'b00, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    issue(2'b01, 32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    issue(2'b01, 32'h7, 32'h5, 1'b0, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0);
    issue(2'b00, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    issue(2'b11, 32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    issue(2'b11, 32'h5, 32'h3, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
    issue(2'b10, 32'hF, 32'h0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0);
    issue(2'b10, 32'h0FFFFFFF, 32'h0, 1'b1, 1'b0, 32'h10000000, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 32'h12345678, 32'h11111111, 1'b1, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b0);
    issue(2'b01, 32'h10, 32'h10, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    req = 1'b1; op = 2'b00; a = 32'h1; b = 32'h2; cin = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_rst_ready", {31'd0, ready}, 32'd1);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_result", result, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    issue(2'b00, 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
